// File: rtl/nes_line_doubler_if.sv
// PPU pixel stream, VGA timing inputs and DAC outputs of the NES line doubler.
// master: PPU / timing-generator side; slave: the doubler itself.
interface nes_line_doubler_if #(
    parameter int IDX_W = 6
);
    logic             pix_valid;
    logic [IDX_W-1:0] pix_index;
    logic             pix_ready;
    logic             line_req;
    logic [9:0]       DrawX;
    logic [9:0]       DrawY;
    logic             h_blank;
    logic             v_blank;
    logic [7:0]       red;
    logic [7:0]       green;
    logic [7:0]       blue;
    logic             underrun;

    modport master (
        output pix_valid, pix_index, DrawX, DrawY, h_blank, v_blank,
        input  pix_ready, line_req, red, green, blue, underrun
    );

    modport slave (
        input  pix_valid, pix_index, DrawX, DrawY, h_blank, v_blank,
        output pix_ready, line_req, red, green, blue, underrun
    );
endinterface

// File: rtl/nes_line_doubler.sv
// NES 256-pixel scanline ping-pong buffer with 2x2 upscale into the 512x480
// VGA window and 2C02 palette lookup.
// Optional build macro: SCANLINE_DIM_EN halves every colour channel on odd
// VGA lines (CRT scanline look); latency is the same in both builds.
module nes_line_doubler #(
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int LINE_W   = 256,
    parameter int V_ACTIVE = 480,
    parameter int IDX_W    = 6
) (
    input  logic              vga_clk,
    input  logic              Reset,
    nes_line_doubler_if.slave bus
);
    localparam int CNT_W  = $clog2(LINE_W + 1);
    localparam int ADDR_W = $clog2(LINE_W);

    // Standard 2C02 RGB palette, index 0x00..0x3F.
    localparam logic [23:0] PALETTE [64] = '{
        24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
        24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
        24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
        24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
        24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
        24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
        24'hFFFFFF, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
        24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
    };

    // Two banks of LINE_W entries; bank select is the address MSB.
    logic [IDX_W-1:0] line_mem [0:2*LINE_W-1];

    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             disp_bank;
    logic             line_req_q;
    logic             underrun_q;
    logic [23:0]      rgb_q;

    logic             accept;
    logic             swap_pt;
    logic [IDX_W-1:0] rd_idx;
    logic [23:0]      pal_rgb;
    logic [23:0]      pix_rgb;

    // wr_cnt never exceeds LINE_W because accepts stop once it gets there.
    assign bus.pix_ready = (wr_cnt < CNT_W'(LINE_W));
    assign accept        = bus.pix_valid & bus.pix_ready;
    assign cnt_next      = wr_cnt + CNT_W'(accept);

    // End of every odd active line hands over the next NES line; the last
    // line of the frame preloads VGA line 0. Line V_ACTIVE-1 is skipped so the
    // 240th NES line is consumed by the end-of-frame swap instead.
    assign swap_pt = (bus.DrawX == 10'(H_TOTAL - 1)) &&
                     ((bus.DrawY[0] && (bus.DrawY < 10'(V_ACTIVE - 1))) ||
                      (bus.DrawY == 10'(V_TOTAL - 1)));

    // Each NES pixel spans two pixel clocks, each NES line two VGA lines.
    assign rd_idx  = line_mem[{disp_bank, bus.DrawX[ADDR_W:1]}];
    assign pal_rgb = PALETTE[rd_idx];

`ifdef SCANLINE_DIM_EN
    assign pix_rgb = bus.DrawY[0] ? {1'b0, pal_rgb[23:17], 1'b0, pal_rgb[15:9], 1'b0, pal_rgb[7:1]}
                                  : pal_rgb;
`else
    assign pix_rgb = pal_rgb;
`endif

    // Line buffer write port; contents are intentionally not reset.
    always_ff @(posedge vga_clk) begin
        if (accept)
            line_mem[{~disp_bank, wr_cnt[ADDR_W-1:0]}] <= bus.pix_index;
    end

    // Write counter, bank swap, line request pulse and sticky underrun.
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            wr_cnt     <= '0;
            disp_bank  <= 1'b0;
            line_req_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            line_req_q <= 1'b0;
            wr_cnt     <= cnt_next;
            if (swap_pt) begin
                // A pixel accepted in this very cycle counts towards "full".
                if (cnt_next == CNT_W'(LINE_W)) begin
                    disp_bank  <= ~disp_bank;
                    wr_cnt     <= '0;
                    line_req_q <= 1'b1;
                end else begin
                    underrun_q <= 1'b1;
                end
            end
        end
    end

    // Registered colour output, one cycle behind DrawX, black in blanking.
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset)
            rgb_q <= '0;
        else if (bus.h_blank | bus.v_blank)
            rgb_q <= '0;
        else
            rgb_q <= pix_rgb;
    end

    assign bus.line_req = line_req_q;
    assign bus.underrun = underrun_q;
    assign bus.red      = rgb_q[23:16];
    assign bus.green    = rgb_q[15:8];
    assign bus.blue     = rgb_q[7:0];
endmodule
